// File: rtl/lcd_4bits_responder.sv
// -----------------------------------------------------------------------------
// lcd_4bits_responder
//
// Device-side model of a 4-bit HD44780-style LCD bus. The bus pins are sampled
// on the system clock. Nibble pairs (high nibble first) are reassembled into
// bytes. The instruction subset used by the LCD write path is executed, DDRAM
// writes are reported as single-cycle strobes, and busy-flag/address reads
// are answered.
//
// Ports
//   i_clock           system clock
//   i_reset_n         asynchronous reset, active low
//   i_lcd_e           bus enable (a byte nibble is taken on its falling edge)
//   i_lcd_rs          register select (0 = instruction, 1 = data)
//   i_lcd_rw          1 = read
//   i_sf_d            bus nibble (SF_D[11:8])
//   o_sf_d_out        read-back nibble
//   o_sf_d_oe         drive enable for o_sf_d_out
//   o_wr_en           one-cycle DDRAM write strobe
//   o_wr_addr         DDRAM address of the write
//   o_wr_data         DDRAM character of the write
//   o_clear_pulse     one-cycle pulse on clear display
//   o_display_on, o_cursor_on, o_blink_on, o_two_line   latched control bits
//   o_ac              address counter
//   o_busy            busy flag
//   o_protocol_err    one-cycle pulse: RS/RW differed between the two nibbles
//   o_nibble_timeout  one-cycle pulse: low nibble never arrived
// -----------------------------------------------------------------------------
module lcd_4bits_responder #(
   parameter int BUSY_CYCLES      = 2000,
   parameter int BUSY_LONG_CYCLES = 82000,
   parameter int NIBBLE_TIMEOUT   = 50000
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_lcd_e,
   input  logic       i_lcd_rs,
   input  logic       i_lcd_rw,
   input  logic [3:0] i_sf_d,
   output logic [3:0] o_sf_d_out,
   output logic       o_sf_d_oe,
   output logic       o_wr_en,
   output logic [6:0] o_wr_addr,
   output logic [7:0] o_wr_data,
   output logic       o_clear_pulse,
   output logic       o_display_on,
   output logic       o_cursor_on,
   output logic       o_blink_on,
   output logic       o_two_line,
   output logic [6:0] o_ac,
   output logic       o_busy,
   output logic       o_protocol_err,
   output logic       o_nibble_timeout
);

   localparam int BUSY_MAX = (BUSY_LONG_CYCLES > BUSY_CYCLES) ? BUSY_LONG_CYCLES : BUSY_CYCLES;
   localparam int BW       = $clog2(BUSY_MAX + 1);
   localparam int TW       = $clog2(NIBBLE_TIMEOUT + 1);

   typedef struct packed {
      logic       e;
      logic       rs;
      logic       rw;
      logic [3:0] d;
   } bus_t;

   typedef enum logic {ST_HI, ST_LO} nib_state_t;

   // Input capture chain (s1 -> s2 -> s3)
   bus_t r_s1, r_s2, r_s3;

   nib_state_t      r_state;
   logic [3:0]      r_hi;
   logic            r_hi_rs;
   logic            r_hi_rw;
   logic [TW-1:0]   r_to_cnt;
   logic [BW-1:0]   r_busy_cnt;
   logic [6:0]      r_ac;
   logic            r_id;
   logic            r_display_on;
   logic            r_cursor_on;
   logic            r_blink_on;
   logic            r_two_line;
   logic            r_wr_en;
   logic [6:0]      r_wr_addr;
   logic [7:0]      r_wr_data;
   logic            r_clear_pulse;
   logic            r_protocol_err;
   logic            r_nibble_timeout;
   logic [3:0]      r_sf_d_out;

   logic            w_fall;
   logic [7:0]      w_byte;
   logic            w_pair_ok;
   logic [6:0]      w_ac_step;
   logic            w_busy;
   logic            w_oe;
   logic [3:0]      w_rd_nibble;

   // s3 holds the last sample taken with E high, so RS/RW/D come from it.
   assign w_fall    = !r_s2.e && r_s3.e;
   assign w_byte    = {r_hi, r_s3.d};
   assign w_pair_ok = (r_hi_rs == r_s3.rs) && (r_hi_rw == r_s3.rw);
   assign w_ac_step = r_id ? (r_ac + 7'd1) : (r_ac - 7'd1);
   assign w_busy    = (r_busy_cnt != '0);
   assign w_oe      = r_s1.e && r_s1.rw;

   // Read-back value: the nibble position follows the reassembly state, so a
   // HI-position read reports busy plus the upper address bits.
   always_comb begin
      w_rd_nibble = 4'h0;
      if (!r_s1.rs) begin
         w_rd_nibble = (r_state == ST_HI) ? {w_busy, r_ac[6:4]} : r_ac[3:0];
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_s3       <= '0;
         r_sf_d_out <= 4'h0;
      end else begin
         r_s1 <= '{e: i_lcd_e, rs: i_lcd_rs, rw: i_lcd_rw, d: i_sf_d};
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (w_oe) begin
            r_sf_d_out <= w_rd_nibble;
         end
      end
   end

   // Nibble reassembly and byte execution.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state          <= ST_HI;
         r_hi             <= 4'h0;
         r_hi_rs          <= 1'b0;
         r_hi_rw          <= 1'b0;
         r_to_cnt         <= '0;
         r_busy_cnt       <= '0;
         r_ac             <= 7'h00;
         r_id             <= 1'b1;
         r_display_on     <= 1'b0;
         r_cursor_on      <= 1'b0;
         r_blink_on       <= 1'b0;
         r_two_line       <= 1'b0;
         r_wr_en          <= 1'b0;
         r_wr_addr        <= 7'h00;
         r_wr_data        <= 8'h00;
         r_clear_pulse    <= 1'b0;
         r_protocol_err   <= 1'b0;
         r_nibble_timeout <= 1'b0;
      end else begin
         r_wr_en          <= 1'b0;
         r_clear_pulse    <= 1'b0;
         r_protocol_err   <= 1'b0;
         r_nibble_timeout <= 1'b0;

         // Later assignments below override this decrement, so a reload in
         // the same cycle as expiry keeps busy asserted.
         if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
         end

         case (r_state)
            ST_HI: begin
               if (w_fall) begin
                  r_hi     <= r_s3.d;
                  r_hi_rs  <= r_s3.rs;
                  r_hi_rw  <= r_s3.rw;
                  r_to_cnt <= '0;
                  r_state  <= ST_LO;
               end
            end

            ST_LO: begin
               if (w_fall) begin
                  r_state <= ST_HI;
                  if (!w_pair_ok) begin
                     r_protocol_err <= 1'b1;
                  end else if (r_hi_rw) begin
                     // Data reads advance the address counter; status reads
                     // have no side effects.
                     if (r_hi_rs) begin
                        r_ac <= w_ac_step;
                     end
                  end else if (r_hi_rs) begin
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= r_ac;
                     r_wr_data  <= w_byte;
                     r_ac       <= w_ac_step;
                     r_busy_cnt <= BW'(BUSY_CYCLES);
                  end else begin
                     // Instruction: the highest set bit selects the command.
                     casez (w_byte)
                        8'b1???????: begin
                           r_ac       <= w_byte[6:0];
                           r_busy_cnt <= BW'(BUSY_CYCLES);
                        end
                        8'b01??????: begin
                           r_busy_cnt <= BW'(BUSY_CYCLES);
                        end
                        8'b001?????: begin
                           r_two_line <= w_byte[3];
                           r_busy_cnt <= BW'(BUSY_CYCLES);
                        end
                        8'b0001????: begin
                           if (!w_byte[3]) begin
                              r_ac <= w_byte[2] ? (r_ac + 7'd1) : (r_ac - 7'd1);
                           end
                           r_busy_cnt <= BW'(BUSY_CYCLES);
                        end
                        8'b00001???: begin
                           r_display_on <= w_byte[2];
                           r_cursor_on  <= w_byte[1];
                           r_blink_on   <= w_byte[0];
                           r_busy_cnt   <= BW'(BUSY_CYCLES);
                        end
                        8'b000001??: begin
                           r_id       <= w_byte[1];
                           r_busy_cnt <= BW'(BUSY_CYCLES);
                        end
                        8'b0000001?: begin
                           r_ac       <= 7'h00;
                           r_busy_cnt <= BW'(BUSY_LONG_CYCLES);
                        end
                        8'b00000001: begin
                           r_ac          <= 7'h00;
                           r_id          <= 1'b1;
                           r_clear_pulse <= 1'b1;
                           r_busy_cnt    <= BW'(BUSY_LONG_CYCLES);
                        end
                        default: begin
                           // 0x00 is a no-operation and leaves busy alone.
                        end
                     endcase
                  end
               end else if (r_to_cnt == TW'(NIBBLE_TIMEOUT - 1)) begin
                  // Lost low nibble: resynchronise on the next nibble.
                  r_state          <= ST_HI;
                  r_nibble_timeout <= 1'b1;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end

            default: r_state <= ST_HI;
         endcase
      end
   end

   assign o_sf_d_out       = r_sf_d_out;
   assign o_sf_d_oe        = w_oe;
   assign o_wr_en          = r_wr_en;
   assign o_wr_addr        = r_wr_addr;
   assign o_wr_data        = r_wr_data;
   assign o_clear_pulse    = r_clear_pulse;
   assign o_display_on     = r_display_on;
   assign o_cursor_on      = r_cursor_on;
   assign o_blink_on       = r_blink_on;
   assign o_two_line       = r_two_line;
   assign o_ac             = r_ac;
   assign o_busy           = w_busy;
   assign o_protocol_err   = r_protocol_err;
   assign o_nibble_timeout = r_nibble_timeout;

endmodule

// File: tb/tb_lcd_4bits_responder.sv
// -----------------------------------------------------------------------------
// tb_lcd_4bits_responder
//
// Drives nibble transactions on the LCD bus and compares the responder against
// a byte-level model of the display (address counter, entry direction, control
// bits, expected DDRAM writes and pulse counts). Directed sequences cover the
// initialisation, data writes, address wrap, busy reads, protocol errors, the
// nibble timeout and a mid-byte reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_lcd_4bits_responder;

   localparam int BUSY_N = 40;
   localparam int BUSY_L = 300;
   localparam int TOUT_N = 200;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       lcd_e, lcd_rs, lcd_rw;
   logic [3:0] sf_d;
   logic [3:0] sf_d_out;
   logic       sf_d_oe, wr_en, clear_pulse, display_on, cursor_on, blink_on, two_line;
   logic [6:0] wr_addr, ac;
   logic [7:0] wr_data;
   logic       busy, protocol_err, nibble_timeout;

   always #5 clk = ~clk;

   lcd_4bits_responder #(
      .BUSY_CYCLES      (BUSY_N),
      .BUSY_LONG_CYCLES (BUSY_L),
      .NIBBLE_TIMEOUT   (TOUT_N)
   ) dut (
      .i_clock          (clk),
      .i_reset_n        (reset_n),
      .i_lcd_e          (lcd_e),
      .i_lcd_rs         (lcd_rs),
      .i_lcd_rw         (lcd_rw),
      .i_sf_d           (sf_d),
      .o_sf_d_out       (sf_d_out),
      .o_sf_d_oe        (sf_d_oe),
      .o_wr_en          (wr_en),
      .o_wr_addr        (wr_addr),
      .o_wr_data        (wr_data),
      .o_clear_pulse    (clear_pulse),
      .o_display_on     (display_on),
      .o_cursor_on      (cursor_on),
      .o_blink_on       (blink_on),
      .o_two_line       (two_line),
      .o_ac             (ac),
      .o_busy           (busy),
      .o_protocol_err   (protocol_err),
      .o_nibble_timeout (nibble_timeout)
   );

   // ---------------------------------------------------------------- checking
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------- monitors
   logic [14:0] got_wr[$];
   int n_clear = 0, n_perr = 0, n_tout = 0;
   int busy_run = 0, last_busy_len = 0;

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (wr_en) got_wr.push_back({wr_addr, wr_data});
         n_clear += int'(clear_pulse);
         n_perr  += int'(protocol_err);
         n_tout  += int'(nibble_timeout);
         if (busy) begin
            busy_run++;
         end else if (busy_run != 0) begin
            last_busy_len = busy_run;
            busy_run = 0;
         end
      end else begin
         busy_run = 0;
      end
   end

   // ---------------------------------------------------------------- model
   int          m_ac;
   bit          m_id, m_disp, m_cur, m_blink, m_two;
   int          m_clear = 0, m_perr = 0, m_tout = 0;
   logic [14:0] exp_wr[$];

   function automatic int ac_move(input int a, input bit up);
      return (a + (up ? 1 : 127)) % 128;
   endfunction

   function automatic void model_reset();
      m_ac = 0; m_id = 1'b1;
      m_disp = 1'b0; m_cur = 1'b0; m_blink = 1'b0; m_two = 1'b0;
      exp_wr.delete();
   endfunction

   // Applies one complete byte; returns 1 when the byte should set busy.
   function automatic bit model_exec(input bit rs, input bit rw, input logic [7:0] b);
      int top;
      if (rw) begin
         if (rs) m_ac = ac_move(m_ac, m_id);
         return 1'b0;
      end
      if (rs) begin
         exp_wr.push_back({7'(m_ac), b});
         m_ac = ac_move(m_ac, m_id);
         return 1'b1;
      end
      top = -1;
      for (int k = 0; k < 8; k++) if (b[k]) top = k;
      case (top)
         7: m_ac = int'(b[6:0]);
         5: m_two = b[3];
         4: if (!b[3]) m_ac = ac_move(m_ac, b[2]);
         3: begin m_disp = b[2]; m_cur = b[1]; m_blink = b[0]; end
         2: m_id = b[1];
         1: m_ac = 0;
         0: begin m_ac = 0; m_id = 1'b1; m_clear++; end
         default: ;
      endcase
      return (top >= 0);
   endfunction

   task automatic check_state(input string ctx);
      check_eq({ctx, "/ac"}, 32'(ac), 32'(m_ac));
      check_eq({ctx, "/display_on"}, 32'(display_on), 32'(m_disp));
      check_eq({ctx, "/cursor_on"}, 32'(cursor_on), 32'(m_cur));
      check_eq({ctx, "/blink_on"}, 32'(blink_on), 32'(m_blink));
      check_eq({ctx, "/two_line"}, 32'(two_line), 32'(m_two));
      check_eq({ctx, "/wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
      while (got_wr.size() > 0 && exp_wr.size() > 0)
         check_eq({ctx, "/wr_addr_data"}, 32'(got_wr.pop_front()), 32'(exp_wr.pop_front()));
      got_wr.delete();
      exp_wr.delete();
      check_eq({ctx, "/clear_pulses"}, 32'(n_clear), 32'(m_clear));
      check_eq({ctx, "/protocol_errs"}, 32'(n_perr), 32'(m_perr));
      check_eq({ctx, "/timeouts"}, 32'(n_tout), 32'(m_tout));
   endtask

   // ---------------------------------------------------------------- bus tasks
   task automatic nib(input bit rs, input bit rw, input logic [3:0] d, output logic [3:0] rd);
      @(posedge clk); #1;
      lcd_rs = rs; lcd_rw = rw; sf_d = d;
      @(posedge clk); #1;
      lcd_e = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check_eq("oe_while_e_high", 32'(sf_d_oe), 32'(rw));
      rd = sf_d_out;
      @(posedge clk); #1;
      lcd_e = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_eq("oe_after_e_low", 32'(sf_d_oe), 32'd0);
   endtask

   task automatic send_byte(input bit rs, input bit rw, input logic [7:0] b,
                            output logic [3:0] hr, output logic [3:0] lr);
      bit sets_busy;
      nib(rs, rw, b[7:4], hr);
      nib(rs, rw, b[3:0], lr);
      sets_busy = model_exec(rs, rw, b);
      $display("byte rs=%0d rw=%0d data=%02h rd=%h%h -> ac=%02h busy=%0d",
               rs, rw, b, hr, lr, ac, busy);
      check_state("byte");
      if (sets_busy) check_eq("busy_after_byte", 32'(busy), 32'd1);
   endtask

   task automatic ins(input logic [7:0] b);
      logic [3:0] hr, lr;
      send_byte(1'b0, 1'b0, b, hr, lr);
   endtask

   task automatic dat(input logic [7:0] b);
      logic [3:0] hr, lr;
      send_byte(1'b1, 1'b0, b, hr, lr);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check_eq("busy_expires", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [3:0] hr, lr, dummy;
      logic [7:0] b;
      bit         rs, rw;
      logic [3:0] exp_lo;
      logic [2:0] exp_hi3;
      int         k;

      reset_n = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; sf_d = 4'h0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset/ac", 32'(ac), 32'd0);
      check_eq("reset/busy", 32'(busy), 32'd0);
      check_eq("reset/oe", 32'(sf_d_oe), 32'd0);
      check_eq("reset/sf_d_out", 32'(sf_d_out), 32'd0);
      check_eq("reset/wr_en", 32'(wr_en), 32'd0);
      check_eq("reset/flags", 32'({display_on, cursor_on, blink_on, two_line}), 32'd0);
      check_eq("reset/pulses", 32'({clear_pulse, protocol_err, nibble_timeout}), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Initialisation sequence
      ins(8'h28); ins(8'h06); ins(8'h0C); ins(8'h01);
      wait_idle();

      // Busy durations, measured from an idle bus
      ins(8'h01); wait_idle();
      check_eq("busy_len_clear", 32'(last_busy_len), 32'(BUSY_L));
      ins(8'h0C); wait_idle();
      check_eq("busy_len_normal", 32'(last_busy_len), 32'(BUSY_N));
      ins(8'h02); wait_idle();
      check_eq("busy_len_home", 32'(last_busy_len), 32'(BUSY_L));
      ins(8'h40); wait_idle();
      check_eq("busy_len_cgram", 32'(last_busy_len), 32'(BUSY_N));
      ins(8'h00); repeat (3) @(negedge clk);
      check_eq("nop_no_busy", 32'(busy), 32'd0);

      // Data writes and address wrap
      dat(8'h48); dat(8'h69);
      ins(8'hC0); dat(8'h41);
      ins(8'hFF); dat(8'h41);
      ins(8'h04); dat(8'h5A);           // decrement: 0x00 -> 0x7F
      ins(8'h06);
      ins(8'h14); ins(8'h10); ins(8'h18); // shift right, left, display shift ignored

      // Busy/address reads
      ins(8'hA5); wait_idle();
      ins(8'h0C);
      send_byte(1'b0, 1'b1, 8'h00, hr, lr);
      check_eq("read_busy_hi", 32'(hr), 32'hA);
      check_eq("read_busy_lo", 32'(lr), 32'h5);
      wait_idle();
      send_byte(1'b0, 1'b1, 8'h00, hr, lr);
      check_eq("read_idle_hi", 32'(hr), 32'h2);
      check_eq("read_idle_lo", 32'(lr), 32'h5);
      check_eq("read_sets_no_busy", 32'(busy), 32'd0);
      send_byte(1'b1, 1'b1, 8'h00, hr, lr);
      check_eq("data_read_hi", 32'(hr), 32'h0);
      check_eq("data_read_lo", 32'(lr), 32'h0);

      // RS and RW mismatches between nibbles
      nib(1'b0, 1'b0, 4'h4, dummy); nib(1'b1, 1'b0, 4'h1, dummy);
      m_perr++;
      check_state("rs_mismatch");
      nib(1'b0, 1'b0, 4'h8, dummy); nib(1'b0, 1'b1, 4'h3, dummy);
      m_perr++;
      check_state("rw_mismatch");

      // Lone high nibble, then idle
      nib(1'b0, 1'b0, 4'h8, dummy);
      repeat (TOUT_N - 40) @(posedge clk);
      @(negedge clk);
      check_eq("timeout_not_early", 32'(n_tout), 32'(m_tout));
      k = 0;
      while (n_tout == m_tout && k < 100) begin
         @(negedge clk);
         k++;
      end
      repeat (3) @(negedge clk);
      m_tout++;
      check_state("timeout");
      ins(8'h85);

      // Randomized traffic
      for (int i = 0; i < 120; i++) begin
         rs = 1'($urandom_range(0, 1));
         rw = ($urandom_range(0, 4) == 0);
         b  = 8'($urandom);
         exp_lo  = rs ? 4'h0 : 4'(m_ac);
         exp_hi3 = rs ? 3'h0 : 3'(m_ac >> 4);
         send_byte(rs, rw, b, hr, lr);
         if (rw) begin
            if (rs) check_eq("rnd_read_hi", 32'(hr), 32'h0);
            else    check_eq("rnd_read_hi_ac", 32'(hr[2:0]), 32'(exp_hi3));
            check_eq("rnd_read_lo", 32'(lr), 32'(exp_lo));
         end
      end

      // Reset between nibbles while busy with the display on
      ins(8'h0F);
      ins(8'h2C);
      nib(1'b0, 1'b0, 4'h8, dummy);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_eq("midreset/ac", 32'(ac), 32'd0);
      check_eq("midreset/busy", 32'(busy), 32'd0);
      check_eq("midreset/flags", 32'({display_on, cursor_on, blink_on, two_line}), 32'd0);
      check_eq("midreset/sf_d_out", 32'(sf_d_out), 32'd0);
      model_reset();
      got_wr.delete();
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      ins(8'h85);
      check_eq("after_reset_ac", 32'(ac), 32'h05);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
